// File: rtl/sync_counter_ctrl_pkg.sv
// Shared encodings for the tick-driven up/down counter controller.
package sync_counter_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/sync_counter_ctrl_if.sv
// Control/status bundle between the controller and its user (panel logic or display stage).
interface sync_counter_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic             clear;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             running;

    modport master (
        output start, stop, clear, up_dn, load, load_val,
        input  count, tc, running
    );

    modport slave (
        input  start, stop, clear, up_dn, load, load_val,
        output count, tc, running
    );
endinterface

// File: rtl/sync_counter_ctrl_tick_edge_detect.sv
// Synchronises an asynchronous level and emits a one-cycle pulse per rising edge.
module tick_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clki,
    input  logic rst_n,
    input  logic async_in,
    output logic tick
);
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   delay_reg;

    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg  <= '0;
            delay_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[SYNC_STAGES-2:0], async_in};
            delay_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    // Pulse width is one cycle regardless of how long async_in stays high.
    assign tick = sync_reg[SYNC_STAGES-1] & ~delay_reg;

endmodule

// File: rtl/sync_counter_ctrl.sv
// Run/pause/idle controlled modulo-(MAX+1) up/down counter advanced by edges of a slow divider output.
module sync_counter_ctrl
    import sync_counter_ctrl_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int MAX         = 15,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clki,
    input  logic                 rst_n,
    input  logic                 clko_in,
    sync_counter_ctrl_if.slave   bus
);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] count_reg, count_next;
    logic             tc_reg, tc_next;
    logic             running_reg;
    logic             tick;

    tick_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_tick (
        .clki     (clki),
        .rst_n    (rst_n),
        .async_in (clko_in),
        .tick     (tick)
    );

    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            count_reg   <= '0;
            tc_reg      <= 1'b0;
            running_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            tc_reg      <= tc_next;
            running_reg <= (state_next == ST_RUN);
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        tc_next    = 1'b0;

        if (bus.clear) begin
            state_next = ST_IDLE;
            count_next = '0;
        end else begin
            case (state_reg)
                ST_RUN:            if (bus.stop)  state_next = ST_PAUSE;
                ST_IDLE, ST_PAUSE: if (bus.start) state_next = ST_RUN;
                default:           state_next = ST_IDLE;
            endcase

            // Wrap is an explicit compare so MAX below 2^WIDTH-1 still works.
            if (bus.load) begin
                count_next = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;
            end else if (tick && (state_reg == ST_RUN)) begin
                if (bus.up_dn == DIR_UP) begin
                    if (count_reg == MAX_V) begin
                        count_next = '0;
                        tc_next    = 1'b1;
                    end else begin
                        count_next = count_reg + ONE_V;
                    end
                end else begin
                    if (count_reg == '0) begin
                        count_next = MAX_V;
                        tc_next    = 1'b1;
                    end else begin
                        count_next = count_reg - ONE_V;
                    end
                end
            end
        end
    end

    assign bus.count   = count_reg;
    assign bus.tc      = tc_reg;
    assign bus.running = running_reg;

endmodule

// File: tb/tb_sync_counter_ctrl.sv
// Randomised scoreboard bench for sync_counter_ctrl with a cycle-level reference model.
module tb_sync_counter_ctrl;
    localparam int WIDTH = 4;
    localparam int MAX   = 9;
    localparam int SYNC  = 2;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;

    logic clki    = 1'b0;
    logic rst_n   = 1'b1;
    logic clko_in = 1'b0;

    sync_counter_ctrl_if #(.WIDTH(WIDTH)) bus ();

    sync_counter_ctrl #(
        .WIDTH       (WIDTH),
        .MAX         (MAX),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clki    (clki),
        .rst_n   (rst_n),
        .clko_in (clko_in),
        .bus     (bus)
    );

    always #5 clki = ~clki;

    typedef struct packed {
        logic [WIDTH-1:0] count;
        logic             tc;
        logic             running;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state
    int m_cnt  = 0;
    int m_mode = M_IDLE;
    bit m_tc   = 1'b0;
    bit hist[$];
    bit ud_v   = 1'b1;
    bit ck_v   = 1'b0;

    task automatic check(string name, int got, int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    function automatic bit hist_at(int idx);
        return (idx >= 0 && idx < hist.size()) ? hist[idx] : 1'b0;
    endfunction

    // Drive one cycle's inputs (called just after a falling edge) and predict the next rising edge.
    task automatic apply(bit st, bit sp, bit cl, bit ld, int lv);
        bit   tick;
        exp_t e;
        bus.start    = st;
        bus.stop     = sp;
        bus.clear    = cl;
        bus.load     = ld;
        bus.load_val = WIDTH'(lv);
        bus.up_dn    = ud_v;
        clko_in      = ck_v;

        // A level first sampled at edge k yields a tick counted at edge k+SYNC.
        tick = hist_at(hist.size() - SYNC) && !hist_at(hist.size() - SYNC - 1);
        hist.push_back(ck_v);
        if (hist.size() > 8) void'(hist.pop_front());

        if (cl) begin
            m_mode = M_IDLE;
            m_cnt  = 0;
            m_tc   = 1'b0;
        end else begin
            m_tc = 1'b0;
            if (ld) begin
                m_cnt = (lv > MAX) ? MAX : lv;
            end else if (tick && m_mode == M_RUN) begin
                if (ud_v) begin
                    m_cnt = m_cnt + 1;
                    if (m_cnt > MAX) begin m_cnt = 0; m_tc = 1'b1; end
                end else begin
                    m_cnt = m_cnt - 1;
                    if (m_cnt < 0) begin m_cnt = MAX; m_tc = 1'b1; end
                end
            end
            if (m_mode == M_RUN) begin
                if (sp) m_mode = M_PAUSE;
            end else if (st) begin
                m_mode = M_RUN;
            end
        end

        e.count   = WIDTH'(m_cnt);
        e.tc      = m_tc;
        e.running = (m_mode == M_RUN);
        exp_q.push_back(e);
    endtask

    task automatic cyc(bit st, bit sp, bit cl, bit ld, int lv);
        @(negedge clki);
        apply(st, sp, cl, ld, lv);
    endtask

    task automatic idle(int n);
        repeat (n) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic edges(int n, int hi, int lo);
        repeat (n) begin
            ck_v = 1'b1; idle(hi);
            ck_v = 1'b0; idle(lo);
        end
    endtask

    task automatic release_reset();
        @(negedge clki);
        rst_n = 1'b1;
        apply(0, 0, 0, 0, 0);
    endtask

    task automatic mid_reset();
        @(negedge clki);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_count",   bus.count,   0);
        check("async_rst_running", bus.running, 0);
        check("async_rst_tc",      bus.tc,      0);
        m_cnt  = 0;
        m_mode = M_IDLE;
        m_tc   = 1'b0;
        hist.delete();
        ck_v = 1'b0;
        bus.start = 0; bus.stop = 0; bus.clear = 0; bus.load = 0;
        clko_in   = 1'b0;
        @(negedge clki);
        release_reset();
    endtask

    // Monitor: compare every registered output one step after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clki);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("count",   bus.count,   e.count);
                check("tc",      bus.tc,      e.tc);
                check("running", bus.running, e.running);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int rem;
        bus.start = 0; bus.stop = 0; bus.clear = 0; bus.load = 0;
        bus.load_val = '0; bus.up_dn = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("reset_count",   bus.count,   0);
        check("reset_tc",      bus.tc,      0);
        check("reset_running", bus.running, 0);
        @(negedge clki);
        release_reset();

        $display("scenario: start then four rising edges counting up");
        ud_v = 1'b1;
        cyc(1, 0, 0, 0, 0);
        edges(4, 3, 3);
        idle(3);

        $display("scenario: load near MAX, wrap up with tc, oversize load saturates");
        cyc(0, 0, 0, 1, 8);
        edges(2, 2, 2);
        idle(2);
        cyc(0, 0, 0, 1, 14);
        idle(2);

        $display("scenario: clear, count down from zero wraps to MAX, load 12 saturates");
        cyc(0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        ud_v = 1'b0;
        edges(1, 2, 3);
        cyc(0, 0, 0, 1, 12);
        idle(2);

        $display("scenario: pause discards ticks, resume continues");
        ud_v = 1'b1;
        cyc(0, 0, 0, 1, 5);
        cyc(0, 1, 0, 0, 0);
        edges(3, 2, 2);
        cyc(1, 0, 0, 0, 0);
        edges(1, 2, 3);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        idle(2);

        $display("scenario: load coincident with tick, clear with start");
        cyc(0, 0, 0, 1, 7);
        ck_v = 1'b1;
        idle(2);
        cyc(0, 0, 0, 1, 3);
        ck_v = 1'b0;
        idle(3);
        cyc(1, 0, 1, 0, 0);
        idle(2);

        $display("scenario: asynchronous reset mid-run at count 8");
        cyc(1, 0, 0, 1, 8);
        idle(3);
        mid_reset();

        $display("scenario: clko_in held high for 1000 cycles");
        cyc(1, 0, 0, 0, 0);
        ck_v = 1'b1;
        idle(1000);
        ck_v = 1'b0;
        idle(4);

        $display("scenario: randomised traffic");
        rem = 3;
        for (int i = 0; i < 2500; i++) begin
            bit st, sp, cl, ld;
            int lv;
            rem--;
            if (rem == 0) begin
                ck_v = ~ck_v;
                rem  = $urandom_range(1, 6);
            end
            if ($urandom_range(0, 15) == 0) ud_v = ~ud_v;
            st = ($urandom_range(0, 7)  == 0);
            sp = ($urandom_range(0, 9)  == 0);
            cl = ($urandom_range(0, 39) == 0);
            ld = ($urandom_range(0, 19) == 0);
            lv = $urandom_range(0, (1 << WIDTH) - 1);
            cyc(st, sp, cl, ld, lv);
        end
        ck_v = 1'b0;
        idle(2);

        @(posedge clki);
        #3;
        check("scoreboard_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
